// File: rtl/lane_merge_pkg.sv
// Shared types for the four-lane merger: lane index, arbitration state.
package lane_merge_pkg;

   localparam int unsigned NumLanes = 4;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic {ARB, LOCKED} merge_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: first requesting lane at or after ptr, wrapping mod 4.
module rr_arbiter4
   import lane_merge_pkg::*;
(
   input  logic [NumLanes-1:0] req,
   input  lane_idx_t           ptr,
   output logic                gnt_valid,
   output lane_idx_t           gnt_idx
);

   lane_idx_t cand;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = ptr;
      cand      = ptr;
      for (int unsigned k = 0; k < NumLanes; k++) begin
         // 2-bit add wraps naturally, giving the mod-4 search order
         cand = ptr + lane_idx_t'(k);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/lane_merge4.sv
// Four-lane to one-lane merger with round-robin arbitration and packet lock on last.
module lane_merge4
   import lane_merge_pkg::*;
#(
   parameter int unsigned Width = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumLanes-1:0]       in_valid_i,
   input  logic [NumLanes-1:0]       in_last_i,
   input  logic [NumLanes*Width-1:0] in_data_i,
   output logic [NumLanes-1:0]       in_ready_o,
   output logic                      out_valid_o,
   output logic [Width-1:0]          out_data_o,
   output logic [1:0]                out_sel_o,
   output logic                      out_last_o,
   input  logic                      out_ready_i
);

   merge_state_t state;
   lane_idx_t    ptr;
   lane_idx_t    lock_lane;

   logic      arb_valid;
   lane_idx_t arb_idx;
   logic      gnt_valid;
   lane_idx_t gnt_idx;
   logic      load_ok;
   logic      xfer;

   rr_arbiter4 u_arb (
      .req       (in_valid_i),
      .ptr       (ptr),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

   always_comb begin
      load_ok = !out_valid_o || out_ready_i;
      // A locked lane keeps its grant even while its valid is low
      if (state == LOCKED) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_lane;
      end else begin
         gnt_valid = arb_valid;
         gnt_idx   = arb_idx;
      end
      in_ready_o = '0;
      if (gnt_valid && load_ok) in_ready_o[gnt_idx] = 1'b1;
      xfer = in_valid_i[gnt_idx] && in_ready_o[gnt_idx];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_sel_o   <= '0;
         out_last_o  <= 1'b0;
         ptr         <= '0;
         lock_lane   <= '0;
         state       <= ARB;
      end else if (xfer) begin
         out_valid_o <= 1'b1;
         out_data_o  <= in_data_i[gnt_idx*Width +: Width];
         out_sel_o   <= gnt_idx;
         out_last_o  <= in_last_i[gnt_idx];
         if (in_last_i[gnt_idx]) begin
            state <= ARB;
            ptr   <= gnt_idx + lane_idx_t'(1);
         end else begin
            state     <= LOCKED;
            lock_lane <= gnt_idx;
         end
      end else if (load_ok) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lane_merge4.sv
// Scoreboard bench for lane_merge4: directed scenarios plus randomized traffic.
module tb_lane_merge4;

   localparam int W = 16;

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b1;
   logic [3:0]    in_valid_i  = '0;
   logic [3:0]    in_last_i   = '0;
   logic [4*W-1:0] in_data_i  = '0;
   logic [3:0]    in_ready_o;
   logic          out_valid_o;
   logic [W-1:0]  out_data_o;
   logic [1:0]    out_sel_o;
   logic          out_last_o;
   logic          out_ready_i = 1'b1;

   lane_merge4 #(.Width(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_last_i   (in_last_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_sel_o   (out_sel_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] d;
      logic [1:0]   s;
      logic         l;
   } beat_t;

   beat_t      q[$];
   logic [1:0] sel_log[$];
   int n_cmp = 0;
   int n_err = 0;

   // reference model state: round-robin pointer, packet lock, output occupancy
   int m_ptr    = 0;
   bit m_locked = 0;
   int m_lock   = 0;
   bit m_outv   = 0;
   int left[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_ready();
      logic lok;
      int   g;
      lok = !m_outv || out_ready_i;
      g   = -1;
      if (m_locked) g = m_lock;
      else
         for (int k = 0; k < 4; k++)
            if (g < 0 && in_valid_i[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (g < 0 || !lok) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   always @(negedge clk_i) check("in_ready", in_ready_o, exp_ready());

   always @(posedge clk_i) begin
      logic [3:0] acc;
      logic       lok;
      beat_t      b;
      int         g;
      if (rst_i) begin
         m_ptr = 0; m_locked = 0; m_lock = 0; m_outv = 0;
         q.delete();
      end else begin
         lok = !m_outv || out_ready_i;
         acc = exp_ready() & in_valid_i;
         if (acc != 4'b0000) begin
            g = 0;
            for (int n = 0; n < 4; n++) if (acc[n]) g = n;
            b.d = in_data_i[g*W +: W];
            b.s = 2'(g);
            b.l = in_last_i[g];
            q.push_back(b);
            if (b.l) begin
               m_ptr = (g + 1) % 4;
               m_locked = 0;
            end else begin
               m_locked = 1;
               m_lock = g;
            end
            m_outv = 1;
         end else if (lok) begin
            m_outv = 0;
         end
      end
   end

   // output monitor: the head of the queue is the beat the output register must hold
   always @(negedge clk_i) begin
      check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
      if (out_valid_o === 1'b1 && q.size() != 0) begin
         check("out_data", 32'(out_data_o), 32'(q[0].d));
         check("out_sel", 32'(out_sel_o), 32'(q[0].s));
         check("out_last", 32'(out_last_o), 32'(q[0].l));
         if (out_ready_i) begin
            sel_log.push_back(out_sel_o);
            void'(q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_lane(input int n, input logic v, input logic l, input logic [W-1:0] d);
      in_valid_i[n]      = v;
      in_last_i[n]       = l;
      in_data_i[n*W +: W] = d;
   endtask

   task automatic clear_lanes();
      in_valid_i = '0;
      in_last_i  = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   task automatic run_all(input int first);
      sel_log.delete();
      for (int n = 0; n < 4; n++) set_lane(n, 1'b1, 1'b1, 16'(n));
      repeat (5) step();
      clear_lanes();
      repeat (2) step();
      check("all_cnt", sel_log.size(), 5);
      for (int i = 0; i < 5 && i < sel_log.size(); i++)
         check("all_sel", 32'(sel_log[i]), (first + i) % 4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] acc;
      int exp_lock [5] = '{0, 1, 1, 1, 0};

      repeat (2) step();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_valid", 32'(out_valid_o), 0);
      check("rst_data", 32'(out_data_o), 0);
      check("rst_sel", 32'(out_sel_o), 0);
      check("rst_last", 32'(out_last_o), 0);

      // single beat on lane 2
      step();
      set_lane(2, 1'b1, 1'b1, 16'hBEEF);
      @(negedge clk_i);
      check("beef_rdy", 32'(in_ready_o), 32'h4);
      step();
      set_lane(2, 1'b0, 1'b0, 16'h0);
      @(negedge clk_i);
      check("beef_valid", 32'(out_valid_o), 1);
      check("beef_data", 32'(out_data_o), 32'hBEEF);
      check("beef_sel", 32'(out_sel_o), 2);
      check("beef_last", 32'(out_last_o), 1);
      step();

      // pointer now 3: lane 3 first, then wrap to lane 0
      run_all(3);
      do_reset();
      run_all(0);

      // lane 1 packet lock while lane 0 stays valid
      do_reset();
      sel_log.delete();
      set_lane(0, 1'b1, 1'b1, 16'h0070);
      step();
      set_lane(0, 1'b1, 1'b1, 16'h0077);
      for (int b = 0; b < 3; b++) begin
         set_lane(1, 1'b1, b == 2, 16'(16'h0011 + b));
         @(negedge clk_i);
         check("lock_rdy", 32'(in_ready_o), 32'h2);
         step();
      end
      set_lane(1, 1'b0, 1'b0, 16'h0);
      @(negedge clk_i);
      check("lock_release", 32'(in_ready_o), 32'h1);
      step();
      clear_lanes();
      repeat (2) step();
      check("lock_cnt", sel_log.size(), 5);
      for (int i = 0; i < 5 && i < sel_log.size(); i++)
         check("lock_sel", 32'(sel_log[i]), exp_lock[i]);

      // output stall
      do_reset();
      set_lane(0, 1'b1, 1'b1, 16'hA5A5);
      step();
      set_lane(0, 1'b0, 1'b0, 16'h0);
      set_lane(1, 1'b1, 1'b1, 16'h5A5A);
      out_ready_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         check("stall_rdy", 32'(in_ready_o), 0);
         check("stall_valid", 32'(out_valid_o), 1);
         check("stall_data", 32'(out_data_o), 32'hA5A5);
         step();
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      check("unstall_rdy", 32'(in_ready_o), 32'h2);
      step();
      set_lane(1, 1'b0, 1'b0, 16'h0);
      @(negedge clk_i);
      check("unstall_data", 32'(out_data_o), 32'h5A5A);
      step();

      // locked lane 3 drops valid for two cycles
      do_reset();
      set_lane(3, 1'b1, 1'b0, 16'h3001);
      step();
      set_lane(3, 1'b0, 1'b0, 16'h0);
      for (int n = 0; n < 3; n++) set_lane(n, 1'b1, 1'b1, 16'(16'h0100 + n));
      @(negedge clk_i);
      check("gap_rdy0", 32'(in_ready_o[2:0]), 0);
      check("gap_valid0", 32'(out_valid_o), 1);
      step();
      @(negedge clk_i);
      check("gap_rdy1", 32'(in_ready_o[2:0]), 0);
      check("gap_bubble1", 32'(out_valid_o), 0);
      step();
      set_lane(3, 1'b1, 1'b1, 16'h3002);
      @(negedge clk_i);
      check("gap_bubble2", 32'(out_valid_o), 0);
      check("gap_rdy3", 32'(in_ready_o), 32'h8);
      step();
      set_lane(3, 1'b0, 1'b0, 16'h0);
      @(negedge clk_i);
      check("gap_after", 32'(in_ready_o), 32'h1);
      check("gap_data", 32'(out_data_o), 32'h3002);
      step();
      clear_lanes();
      step();

      // reset while locked on lane 2
      do_reset();
      set_lane(2, 1'b1, 1'b0, 16'h2001);
      step();
      set_lane(2, 1'b1, 1'b0, 16'h2002);
      set_lane(0, 1'b1, 1'b1, 16'h0001);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("mrst_valid", 32'(out_valid_o), 0);
      check("mrst_data", 32'(out_data_o), 0);
      check("mrst_sel", 32'(out_sel_o), 0);
      check("mrst_last", 32'(out_last_o), 0);
      check("mrst_rdy", 32'(in_ready_o), 32'h1);
      step();
      clear_lanes();
      step();

      // randomized traffic
      do_reset();
      for (int n = 0; n < 4; n++) left[n] = $urandom_range(1, 4);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk_i);
         acc = in_valid_i & in_ready_o;
         @(posedge clk_i);
         #1;
         rst_i = ($urandom_range(0, 399) == 0);
         for (int n = 0; n < 4; n++) begin
            if (acc[n]) begin
               left[n]--;
               if (left[n] <= 0) left[n] = $urandom_range(1, 4);
            end
            if (!(in_valid_i[n] && !acc[n] && $urandom_range(0, 9) != 0))
               set_lane(n, $urandom_range(0, 99) < 60, left[n] == 1, 16'($urandom));
         end
         out_ready_i = ($urandom_range(0, 99) < 70);
      end
      rst_i = 1'b0;
      clear_lanes();
      out_ready_i = 1'b1;
      repeat (4) step();
      check("drain_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lane_merge4.md
Name: lane_merge4

Overview:
- Four-lane to one-lane merger. It is the collecting counterpart of the 1-to-4 registered demux that fans `value_i` out to lanes a/b/c/d.
- Accepts beats from four valid/ready input lanes, arbitrates round-robin, and drives one registered output stream tagged with the source lane index.
- Packet lock via per-lane `last` keeps multi-beat packets contiguous on the output.

Parameters:
- Width, 16, data width of every lane and of the output.

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  4  per-lane valid; bit n = lane n (0=a, 1=b, 2=c, 3=d).
- `in_last_i`  in  4  per-lane end-of-packet marker, qualified by `in_valid_i[n]`.
- `in_data_i`  in  4*Width  packed lane data; lane n at bits [n*Width +: Width].
- `in_ready_o`  out  4  per-lane ready; at most one bit high per cycle.
- `out_valid_o`  out  1  output beat valid (registered).
- `out_data_o`  out  Width  output data (registered).
- `out_sel_o`  out  2  source lane index of the current output beat (registered).
- `out_last_o`  out  1  end-of-packet marker of the current output beat (registered).
- `out_ready_i`  in  1  downstream ready.

Behaviour:
- Clock and reset: single clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values:
  - `out_valid_o`=0, `out_data_o`='0, `out_sel_o`=0, `out_last_o`=0.
  - Round-robin pointer `ptr`=0; state=ARB.
- Load enable: `load_ok` = !`out_valid_o` || `out_ready_i`. The output register holds its value whenever `load_ok`=0.
- Handshakes:
  - Input transfer on lane n when `in_valid_i[n]` && `in_ready_o[n]`.
  - Output transfer when `out_valid_o` && `out_ready_i`.
  - `in_ready_o` may depend combinationally on `in_valid_i` and `out_ready_i`. `out_valid_o` never depends on `out_ready_i`.
- Grant, state ARB: `grant` = first n with `in_valid_i[n]`=1, searching `ptr`, `ptr`+1, ... mod 4.
  - `in_ready_o[grant]` = `load_ok`; all other ready bits are 0.
  - No valid lane: `in_ready_o`=0.
- Grant, state LOCKED: `grant` = `lock_lane` only. `in_ready_o[lock_lane]` = `load_ok`; all other lanes are stalled even if valid.
- On an input transfer from lane g (registered next edge):
  - `out_data_o` <= `in_data_i[g]`; `out_sel_o` <= g; `out_last_o` <= `in_last_i[g]`; `out_valid_o` <= 1.
- State transitions:
  - ARB -> LOCKED when transfer with `in_last_i[g]`=0; `lock_lane` <= g.
  - LOCKED -> ARB when transfer from `lock_lane` with `in_last_i`=1.
  - Any accepted beat with `last`=1 from ARB stays in ARB.
- Pointer update: `ptr` <= g+1 mod 4 on every transfer with `last`=1. `ptr` does not change mid-packet.
- Output drain: if `load_ok` && no input transfer this cycle, `out_valid_o` <= 0. Data, sel and last hold their last values.
- Latency and throughput:
  - Input beat appears on the output on the cycle after acceptance.
  - Full throughput is 1 beat/cycle with `out_ready_i` held high.
  - Back-to-back transfer is allowed (simultaneous output drain and load in one cycle).
- Boundary conditions:
  - `out_ready_i`=0 with `out_valid_o`=1: all `in_ready_o`=0; output stable.
  - All four lanes valid with `ptr`=3: lane 3 is granted first, then lane 0.
  - Locked lane deasserts valid mid-packet: stay LOCKED, insert output bubbles, other lanes wait.
  - `rst_i` mid-packet: return to reset values next edge. A partial packet already emitted is not completed.
  - `in_last_i`/`in_data_i` on a lane with `valid`=0 are ignored.

Decomposition:
- Package `lane_merge_pkg`:
  - `NumLanes`=4.
  - `typedef logic [1:0] lane_idx_t`.
  - `typedef enum logic {ARB, LOCKED} merge_state_t`.
- Sub-module `rr_arbiter4`: combinational. Inputs `req[3:0]` and `ptr` (`lane_idx_t`); outputs `gnt_valid` and `gnt_idx`.
- FSM, output register and pointer stay in `lane_merge4`.

Test Plan:
- Reset, then a single beat on lane 2, `data` 16'hBEEF, `last`=1, `out_ready_i`=1:
  - `in_ready_o`=4'b0100 on the accept cycle.
  - Next cycle `out_valid_o`=1, `out_data_o`=16'hBEEF, `out_sel_o`=2, `out_last_o`=1.
  - `ptr` becomes 3.
- All lanes valid, single-beat packets with data 16'h000n, `out_ready_i`=1, from reset: output `sel` sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Lane 1 sends a 3-beat packet (16'h0011, 16'h0012, 16'h0013, `last` on beat 3) while lane 0 is valid throughout:
  - Output carries `sel`=1 for three consecutive beats.
  - Lane 0 beat follows, and `in_ready_o[0]`=0 during the lock.
- Output stall: beat 16'hA5A5 loaded, `out_ready_i`=0 for 5 cycles:
  - `out_valid_o`/`out_data_o` stay stable and `in_ready_o`=0.
  - When `out_ready_i`=1, the next waiting beat loads the same cycle.
- Locked lane 3 drops valid for 2 cycles mid-packet: `out_valid_o`=0 for 2 cycles; lanes 0-2 are not granted until lane 3 delivers `last`.
- `rst_i` asserted mid-packet (state LOCKED on lane 2): next edge all outputs are 0 and state is ARB; lane 0 is granted first afterwards.
